// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling UART receiver.
// Synchronises rx_in, detects the start edge and samples every bit at mid-bit.
// Data is shifted in LSB first, then optional parity and the stop bit are checked.
// The completed byte and its error flags are registered one clk after the stop sample.
// Optional build macro UART_RX_OVERRUN_EN: rx_valid becomes a level that is
// acknowledged through rd_ack, and a sticky overrun flag is added.
//
//   state  | meaning
//   IDLE   | waiting for a 1->0 edge on the synchronised line
//   START  | counting to mid start bit, rejecting glitches
//   DATA   | sampling DATA_BITS data bits, LSB first
//   PARITY | sampling the parity bit (only when parity was enabled at frame start)
//   STOP   | sampling the stop bit, back to IDLE on that same tick
module uart_rx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic       parity_en,
`ifdef UART_RX_OVERRUN_EN
  input  logic       rd_ack,
  output logic       overrun,
`endif
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int            TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt, w_tick_nxt;
  logic [3:0]    r_bit_cnt, w_bit_nxt;

  logic r_sync1, r_sync2, r_prev_rs;
  logic w_rs;

  logic w_frame_start, w_shift, w_par_sample, w_stop_sample;

  logic [7:0] r_shift;
  logic       r_par_bit, r_par_en, r_stop_bit, r_done;
  logic       w_par_err;

  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_par_err, r_frm_err;
`ifdef UART_RX_OVERRUN_EN
  logic       r_overrun;
`endif

  assign w_rs = r_sync2;

  // Two-flop synchroniser on the raw line plus the previous tick's sample for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev_rs <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      if (sample_tick) r_prev_rs <= w_rs;
    end
  end

  // FSM state and bit-timing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
    end
  end

  // Next-state logic and sampling strobes; nothing moves without sample_tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_frame_start = 1'b0;
    w_shift       = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    if (sample_tick) begin
      case (r_state)
        S_IDLE: begin
          // Requiring a high previous sample keeps a held-low line from re-triggering.
          if (r_prev_rs && !w_rs) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == TICK_MID) begin
            w_tick_nxt = '0;
            if (w_rs) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt   = S_DATA;
              w_bit_nxt     = '0;
              w_frame_start = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tick_cnt == TICK_END) begin
            w_shift    = 1'b1;
            w_tick_nxt = '0;
            w_bit_nxt  = r_bit_cnt + 4'd1;
            if (r_bit_cnt == BIT_LAST) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == TICK_END) begin
            w_par_sample = 1'b1;
            w_tick_nxt   = '0;
            w_state_nxt  = S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_STOP: begin
          if (r_tick_cnt == TICK_END) begin
            w_stop_sample = 1'b1;
            w_tick_nxt    = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
        end
      endcase
    end
  end

  // Shift register and captured parity/stop samples; parity_en is frozen at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop_bit <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_stop_sample;
      if (w_frame_start) begin
        r_shift  <= '0;
        r_par_en <= parity_en;
      end
      if (w_shift)       r_shift[r_bit_cnt[2:0]] <= w_rs;
      if (w_par_sample)  r_par_bit  <= w_rs;
      if (w_stop_sample) r_stop_bit <= w_rs;
    end
  end

  // Unused upper bits of r_shift are zero, so the full reduction equals the data parity.
  assign w_par_err = r_par_en & (r_par_bit != ((^r_shift) ^ ODD));

  // Host-side output registers, updated on the clk after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      r_overrun  <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_OVERRUN_EN
      if (rd_ack) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (r_done) begin
        if (!r_rx_valid || rd_ack) begin
          r_rx_data  <= r_shift;
          r_par_err  <= w_par_err;
          r_frm_err  <= ~r_stop_bit;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
`else
      r_rx_valid <= r_done;
      if (r_done) begin
        r_rx_data <= r_shift;
        r_par_err <= w_par_err;
        r_frm_err <= ~r_stop_bit;
      end
`endif
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_par_err;
  assign frame_err  = r_frm_err;
  assign rx_busy    = (r_state != S_IDLE);
`ifdef UART_RX_OVERRUN_EN
  assign overrun    = r_overrun;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: directed corner cases plus randomised frames,
// checked against a frame-level reference queue.
module tb_uart_rx_fsm;

  localparam int OS     = 16;
  localparam int CPT    = 4;
  localparam int BITCLK = OS * CPT;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick = 1'b0;
  logic       rx_in;
  logic       parity_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_OVERRUN_EN
  logic       rd_ack = 1'b0;
  logic       overrun;
  logic       auto_ack = 1'b1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  logic   prev_v = 1'b0;
  int     ph = 0;

  uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .rx_in      (rx_in),
    .parity_en  (parity_en),
`ifdef UART_RX_OVERRUN_EN
    .rd_ack     (rd_ack),
    .overrun    (overrun),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial forever #5 clk = ~clk;

  // One sample_tick every CPT clocks.
  initial begin
    forever begin
      @(negedge clk);
      sample_tick = (ph == 0);
      ph = (ph + 1) % CPT;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) rd_ack = rx_valid;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: records delivered frames.
  always @(negedge clk) begin
`ifdef UART_RX_OVERRUN_EN
    if (rx_valid && !prev_v) obs_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
`else
    if (rx_valid) obs_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
    if (prev_v) check("valid_pulse", 32'(rx_valid), 32'd0);
`endif
    prev_v <= rx_valid;
  end

  task automatic bit_period(input logic v);
    rx_in = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  // Drives one frame; parity_en is scrambled mid-frame to show it is only sampled at frame start.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stopv);
    parity_en = pe;
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == 2) parity_en = 1'($urandom_range(0, 1));
      repeat (BITCLK) @(negedge clk);
    end
    if (pe) bit_period(pbit);
    bit_period(stopv);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stopv);
    exp_q.push_back('{d: d, pe: pe & (pbit != (^d)), fe: ~stopv});
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (2 * BITCLK) @(negedge clk);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
      check({tag, "_perr"}, 32'(obs_q[i].pe), 32'(exp_q[i].pe));
      check({tag, "_ferr"}, 32'(obs_q[i].fe), 32'(exp_q[i].fe));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       pe, pbit, stopv;

    reset     = 1'b1;
    rx_in     = 1'b1;
    parity_en = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Idle line after reset
    repeat (100 * CPT) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_frames", 32'(obs_q.size()), 32'd0);
`ifdef UART_RX_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif

    // Plain frame
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    bit_period(1'b1);
    drain("a5");

    // Parity good then bad
    expect_frame(8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    bit_period(1'b1);
    drain("par");

    // Framing error followed by a long break
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (30 * BITCLK) @(negedge clk);
    check("break_busy", 32'(rx_busy), 32'd0);
    drain("brk");
    bit_period(1'b1);
    bit_period(1'b1);
    d = 8'($urandom);
    expect_frame(d, 1'b0, 1'b0, 1'b1);
    send_frame(d, 1'b0, 1'b0, 1'b1);
    bit_period(1'b1);
    drain("after_brk");

    // Short low glitch is rejected as a false start
    rx_in = 1'b0;
    repeat (4 * CPT) @(negedge clk);
    rx_in = 1'b1;
    check("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (20 * CPT) @(negedge clk);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    drain("glitch");

    // Reset during bit 3 of 0xFF
    parity_en = 1'b0;
    bit_period(1'b0);
    rx_in = 1'b1;
    repeat (3 * BITCLK + BITCLK / 2) @(negedge clk);
    check("pre_reset_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(rx_busy), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    repeat (6 * BITCLK) @(negedge clk);
    check("reset_data_hold", 32'(rx_data), 32'd0);
    drain("mid_reset");

    // Randomised frames, some back-to-back
    for (int k = 0; k < 24; k++) begin
      d     = 8'($urandom);
      pe    = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      stopv = ($urandom_range(0, 4) != 0);
      expect_frame(d, pe, pbit, stopv);
      send_frame(d, pe, pbit, stopv);
      if (!stopv) bit_period(1'b1);
      else begin
        rx_in = 1'b1;
        repeat ($urandom_range(0, 2) * (BITCLK / 2)) @(negedge clk);
      end
    end
    rx_in = 1'b1;
    drain("rand");

`ifdef UART_RX_OVERRUN_EN
    // Overrun: two frames with no acknowledge
    auto_ack = 1'b0;
    @(negedge clk);
    rd_ack = 1'b0;
    expect_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    bit_period(1'b1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("ack_valid", 32'(rx_valid), 32'd0);
    check("ack_overrun", 32'(overrun), 32'd0);
    drain("ovr");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
